dds_sweep_ctrl: RTL and testbench

Sequencer for the DDS tone generator's configuration channel. Converts raw active-low push-buttons into debounced step events, or auto-sweeps the tone when sweep mode is enabled. Maintains the output frequency index 1..30 (units of 100 Hz). Delivers each new phase increment to the DDS `s_axis_config` port over a valid/ready handshake. Sits between the board keys and the DDS core, replacing direct key-to-config wiring.

---
 rtl/dds_ctrl_pkg.sv | 30 +++
 rtl/key_debounce.sv | 65 ++++++
 rtl/dds_sweep_ctrl.sv | 165 ++++++++++++++++
 tb/tb_dds_sweep_ctrl.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/dds_ctrl_pkg.sv
// dds_ctrl_pkg
// Shared definitions for the DDS sweep controller: the FSM state encoding,
// the data widths, the default frequency-index limits, the pending key
// event encoding and the frequency-index to phase-increment mapping.
package dds_ctrl_pkg;

  localparam int FREQ_W       = 6;
  localparam int PINC_W       = 24;
  localparam int FMIN_DEFAULT = 1;
  localparam int FMAX_DEFAULT = 30;

  typedef enum logic [1:0] {
    S_LOAD  = 2'd0,
    S_HOLD  = 2'd1,
    S_DWELL = 2'd2
  } state_e;

  // Key event vector layout: bit 0 = step down, bit 1 = step up.
  localparam logic [1:0] EV_NONE = 2'b00;
  localparam logic [1:0] EV_DN   = 2'b01;
  localparam logic [1:0] EV_UP   = 2'b10;

  // pinc = freq*10 + ((freq+2)>>2); for example 1 -> 10 and 30 -> 308.
  function automatic logic [PINC_W-1:0] freq2pinc(input logic [FREQ_W-1:0] f);
    logic [PINC_W-1:0] fz;
    fz = PINC_W'(f);
    return (fz << 3) + (fz << 1) + ((fz + PINC_W'(2)) >> 2);
  endfunction

endpackage

// File: rtl/key_debounce.sv
// key_debounce
// Conditions one raw active-low push-button: a 2-FF synchronizer followed
// by a stability counter. A new level is accepted after DEB_CYC consecutive
// equal synchronized samples. An accepted high->low transition produces a
// single-cycle press pulse; a held key never repeats.
// Ports:
//   clk_i   - clock
//   rst_ni  - asynchronous active-low reset (released level, counter 0)
//   key_ni  - raw key, active-low, asynchronous to clk_i
//   press_o - one-cycle press event
module key_debounce #(
  parameter int DEB_CYC = 1_000_000
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic key_ni,
  output logic press_o
);

  localparam int CNT_W = (DEB_CYC > 1) ? $clog2(DEB_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEB_CYC - 1);

  logic [1:0]       sync_q;
  logic             lvl_q, lvl_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             press_q, press_d;
  logic             smp;

  assign smp = sync_q[1];

  // The key is one bit, so "sample differs from the accepted level" is the
  // same as "the sample has been changing": any return to the accepted
  // level restarts the qualification run from zero.
  always_comb begin
    lvl_d   = lvl_q;
    cnt_d   = cnt_q;
    press_d = 1'b0;
    if (smp == lvl_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_MAX) begin
      lvl_d   = smp;
      cnt_d   = '0;
      press_d = ~smp;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q  <= 2'b11;
      lvl_q   <= 1'b1;
      cnt_q   <= '0;
      press_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], key_ni};
      lvl_q   <= lvl_d;
      cnt_q   <= cnt_d;
      press_q <= press_d;
    end
  end

  assign press_o = press_q;

endmodule

// File: rtl/dds_sweep_ctrl.sv
// dds_sweep_ctrl
// Configuration-channel sequencer for the DDS tone generator. Debounced
// keys step the frequency index FMIN..FMAX (wrapping), or, with sweep mode,
// the index auto-increments every DWELL_CYC cycles. Every new index is
// pushed to the DDS as a phase increment over a valid/ready handshake.
// Optional feature macro: DDS_SWEEP_EN (undefined: no sweep, sweep_en
// ignored, sweep_active tied low).
// Ports:
//   clk_50m      - system clock
//   rst_n        - asynchronous active-low reset
//   key[1:0]     - raw active-low keys; [0] steps down, [1] steps up
//   sweep_en     - level, selects auto-sweep
//   cfg_tvalid   - config word valid
//   cfg_tready   - DDS accepts config
//   cfg_tdata    - phase increment for the committed index
//   freq         - committed frequency index
//   sweep_active - high while dwelling in sweep mode
module dds_sweep_ctrl
  import dds_ctrl_pkg::*;
#(
  parameter int DEB_CYC   = 1_000_000,
  parameter int DWELL_CYC = 5_000_000,
  parameter int FMIN      = FMIN_DEFAULT,
  parameter int FMAX      = FMAX_DEFAULT
) (
  input  logic              clk_50m,
  input  logic              rst_n,
  input  logic [1:0]        key,
  input  logic              sweep_en,
  output logic              cfg_tvalid,
  input  logic              cfg_tready,
  output logic [PINC_W-1:0] cfg_tdata,
  output logic [FREQ_W-1:0] freq,
  output logic              sweep_active
);

  localparam logic [FREQ_W-1:0] F_LO = FREQ_W'(FMIN);
  localparam logic [FREQ_W-1:0] F_HI = FREQ_W'(FMAX);

  logic [1:0] press_ev;

  for (genvar gi = 0; gi < 2; gi++) begin : g_key
    key_debounce #(
      .DEB_CYC (DEB_CYC)
    ) u_deb (
      .clk_i   (clk_50m),
      .rst_ni  (rst_n),
      .key_ni  (key[gi]),
      .press_o (press_ev[gi])
    );
  end

  state_e            state_q, state_d;
  logic [FREQ_W-1:0] freq_q, freq_d;
  logic [1:0]        pend_q, pend_d;
  logic              valid_q;
  logic [FREQ_W-1:0] freq_inc, freq_dec;
  logic [1:0]        hold_ev;

`ifdef DDS_SWEEP_EN
  localparam int DW_W = (DWELL_CYC > 1) ? $clog2(DWELL_CYC) : 1;
  localparam logic [DW_W-1:0] DW_MAX = DW_W'(DWELL_CYC - 1);
  logic [DW_W-1:0] dwell_q, dwell_d;
`else
  logic unused_sweep_en;
  assign unused_sweep_en = sweep_en;
`endif

  assign freq_inc = (freq_q == F_HI) ? F_LO : freq_q + 1'b1;
  assign freq_dec = (freq_q == F_LO) ? F_HI : freq_q - 1'b1;

  // In HOLD a live event takes precedence over one parked during LOAD, so
  // the most recent key action is the one acted on.
  assign hold_ev = (press_ev != EV_NONE) ? press_ev : pend_q;

  always_comb begin
    state_d = state_q;
    freq_d  = freq_q;
    pend_d  = pend_q;
`ifdef DDS_SWEEP_EN
    dwell_d = dwell_q;
`endif
    case (state_q)
      S_LOAD: begin
        if (press_ev == (EV_DN | EV_UP)) pend_d = EV_NONE;
        else if (press_ev != EV_NONE)    pend_d = press_ev;
        if (valid_q && cfg_tready) begin
`ifdef DDS_SWEEP_EN
          if (sweep_en) begin
            state_d = S_DWELL;
            pend_d  = EV_NONE;
            dwell_d = '0;
          end else begin
            state_d = S_HOLD;
          end
`else
          state_d = S_HOLD;
`endif
        end
      end
      S_HOLD: begin
        pend_d = EV_NONE;
`ifdef DDS_SWEEP_EN
        if (sweep_en) begin
          state_d = S_DWELL;
          dwell_d = '0;
        end else
`endif
        if (hold_ev == EV_DN) begin
          freq_d  = freq_dec;
          state_d = S_LOAD;
        end else if (hold_ev == EV_UP) begin
          freq_d  = freq_inc;
          state_d = S_LOAD;
        end
      end
`ifdef DDS_SWEEP_EN
      S_DWELL: begin
        if (!sweep_en) begin
          state_d = S_HOLD;
        end else if (dwell_q == DW_MAX) begin
          freq_d  = freq_inc;
          dwell_d = '0;
          state_d = S_LOAD;
        end else begin
          dwell_d = dwell_q + 1'b1;
        end
      end
`endif
      default: state_d = S_LOAD;
    endcase
  end

  // valid is registered from the next state so that it is low during reset
  // yet rises on the first edge after release while the FSM sits in LOAD.
  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_LOAD;
      freq_q  <= F_LO;
      pend_q  <= EV_NONE;
      valid_q <= 1'b0;
`ifdef DDS_SWEEP_EN
      dwell_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      freq_q  <= freq_d;
      pend_q  <= pend_d;
      valid_q <= (state_d == S_LOAD);
`ifdef DDS_SWEEP_EN
      dwell_q <= dwell_d;
`endif
    end
  end

  assign cfg_tvalid = valid_q;
  assign cfg_tdata  = freq2pinc(freq_q);
  assign freq       = freq_q;
`ifdef DDS_SWEEP_EN
  assign sweep_active = (state_q == S_DWELL);
`else
  assign sweep_active = 1'b0;
`endif

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
module tb_dds_sweep_ctrl;

  localparam int DEB   = 8;
  localparam int DWELL = 16;

  logic        clk_50m = 1'b0;
  logic        rst_n;
  logic [1:0]  key;
  logic        sweep_en;
  logic        cfg_tvalid;
  logic        cfg_tready;
  logic [23:0] cfg_tdata;
  logic [5:0]  freq;
  logic        sweep_active;

  dds_sweep_ctrl #(
    .DEB_CYC   (DEB),
    .DWELL_CYC (DWELL),
    .FMIN      (1),
    .FMAX      (30)
  ) dut (
    .clk_50m      (clk_50m),
    .rst_n        (rst_n),
    .key          (key),
    .sweep_en     (sweep_en),
    .cfg_tvalid   (cfg_tvalid),
    .cfg_tready   (cfg_tready),
    .cfg_tdata    (cfg_tdata),
    .freq         (freq),
    .sweep_active (sweep_active)
  );

  always #10 clk_50m = ~clk_50m;

  typedef struct {
    int f;
    int d;
  } exp_t;

  exp_t sb_q[$];
  int   hs_time[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   hs_cnt   = 0;
  int   cyc      = 0;

  task automatic check(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got=%0d expected=%0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int pinc_model(input int f);
    return f * 10 + (f + 2) / 4;
  endfunction

  task automatic push_exp(input int f);
    exp_t e;
    e.f = f;
    e.d = pinc_model(f);
    sb_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk_50m);
    #1;
  endtask

  task automatic wait_hs(input int target);
    int n;
    n = 0;
    while (hs_cnt < target && n < 300) begin
      tick();
      n++;
    end
    check("hs_count", hs_cnt, target);
  endtask

  // mask bit set = that key held low for n cycles, then released and settled.
  task automatic press(input logic [1:0] mask, input int n);
    key = ~mask;
    repeat (n) tick();
    key = 2'b11;
    repeat (DEB + 6) tick();
  endtask

  initial begin
    forever begin
      @(posedge clk_50m);
      cyc++;
    end
  end

  // Monitor: scoreboard pop on each handshake plus hold-stability checks.
  initial begin
    logic        prev_valid;
    logic        prev_hs;
    logic [23:0] prev_data;
    logic [5:0]  prev_freq;
    exp_t        e;
    prev_valid = 1'b0;
    prev_hs    = 1'b0;
    prev_data  = '0;
    prev_freq  = '0;
    forever begin
      @(negedge clk_50m);
      if (!rst_n) begin
        prev_valid = 1'b0;
        prev_hs    = 1'b0;
      end else begin
        if (prev_valid && !prev_hs) begin
          check("valid_hold", cfg_tvalid, 1);
          check("data_hold", cfg_tdata, prev_data);
          check("freq_hold", freq, prev_freq);
        end
        if (cfg_tvalid && cfg_tready) begin
          hs_cnt++;
          hs_time.push_back(cyc);
          $display("handshake %0d cycle=%0d freq=%0d tdata=%0d", hs_cnt, cyc, freq, cfg_tdata);
          if (sb_q.size() == 0) begin
            check("hs_expected", sb_q.size(), 1);
          end else begin
            e = sb_q.pop_front();
            check("hs_freq", freq, e.f);
            check("hs_data", cfg_tdata, e.d);
          end
        end
        prev_valid = cfg_tvalid;
        prev_hs    = cfg_tvalid && cfg_tready;
        prev_data  = cfg_tdata;
        prev_freq  = freq;
      end
    end
  end

  initial begin
    int h;
    int t0;
    rst_n      = 1'b0;
    key        = 2'b11;
    sweep_en   = 1'b0;
    cfg_tready = 1'b0;
    repeat (3) tick();

    // Reset state.
    check("rst_valid", cfg_tvalid, 0);
    check("rst_freq", freq, 1);
    check("rst_tdata", cfg_tdata, pinc_model(1));
    check("rst_sweep_active", sweep_active, 0);

    // Initial push of freq 1, then idle in HOLD.
    cfg_tready = 1'b1;
    push_exp(1);
    rst_n = 1'b1;
    wait_hs(1);
    repeat (3) tick();
    check("idle_valid", cfg_tvalid, 0);
    check("idle_freq", freq, 1);

    // Down key wraps 1 -> 30.
    push_exp(30);
    press(2'b01, 20);
    wait_hs(2);
    check("down_freq", freq, 30);

    // Short press and bounce produce no event.
    h = hs_cnt;
    press(2'b01, 5);
    key = 2'b10; repeat (5) tick();
    key = 2'b11; tick();
    key = 2'b10; repeat (5) tick();
    key = 2'b11; tick();
    key = 2'b10; repeat (5) tick();
    key = 2'b11; repeat (DEB + 6) tick();
    check("short_press_hs", hs_cnt, h);
    check("short_press_freq", freq, 30);

    // Up key wraps 30 -> 1.
    push_exp(1);
    press(2'b10, 20);
    wait_hs(h + 1);
    check("up_freq", freq, 1);

    // Both keys together: discarded.
    h = hs_cnt;
    press(2'b11, 20);
    check("both_hs", hs_cnt, h);
    check("both_freq", freq, 1);

    // Stalled ready with an up event parked meanwhile.
    cfg_tready = 1'b0;
    push_exp(30);
    press(2'b01, 20);
    check("stall_valid", cfg_tvalid, 1);
    check("stall_freq", freq, 30);
    push_exp(1);
    press(2'b10, 20);
    repeat (10) tick();
    check("stall_valid2", cfg_tvalid, 1);
    check("stall_hs", hs_cnt, h);
    cfg_tready = 1'b1;
    wait_hs(h + 2);
    repeat (3) tick();
    check("pending_freq", freq, 1);
    check("pending_idle", cfg_tvalid, 0);

`ifdef DDS_SWEEP_EN
    // Step down to 29, then sweep 30, 1, 2.
    h = hs_cnt;
    push_exp(30);
    press(2'b01, 20);
    push_exp(29);
    press(2'b01, 20);
    wait_hs(h + 2);
    check("pre_sweep_freq", freq, 29);
    t0 = hs_time.size();
    push_exp(30);
    push_exp(1);
    push_exp(2);
    sweep_en = 1'b1;
    wait_hs(h + 5);
    check("sweep_gap1", hs_time[t0 + 1] - hs_time[t0], DWELL + 1);
    check("sweep_gap2", hs_time[t0 + 2] - hs_time[t0 + 1], DWELL + 1);
    repeat (5) tick();
    check("dwell_active", sweep_active, 1);
    sweep_en = 1'b0;
    repeat (2) tick();
    check("dwell_exit_active", sweep_active, 0);
    check("dwell_exit_freq", freq, 2);
    check("dwell_exit_valid", cfg_tvalid, 0);
`else
    // Sweep request has no effect in this build.
    h = hs_cnt;
    t0 = 0;
    sweep_en = 1'b1;
    repeat (40) begin
      tick();
      if (sweep_active) t0++;
    end
    check("nosweep_active_cycles", t0, 0);
    check("nosweep_hs", hs_cnt, h);
    check("nosweep_freq", freq, 1);
    sweep_en = 1'b0;
`endif

    // Reset while a config word is stalled.
    h = freq;
    cfg_tready = 1'b0;
    press(2'b10, 20);
    check("pre_rst_valid", cfg_tvalid, 1);
    check("pre_rst_freq", freq, (h == 30) ? 1 : h + 1);
    @(posedge clk_50m);
    #3;
    rst_n = 1'b0;
    #1;
    check("async_rst_valid", cfg_tvalid, 0);
    check("async_rst_freq", freq, 1);
    check("async_rst_tdata", cfg_tdata, pinc_model(1));
    sb_q.delete();
    repeat (2) tick();
    h = hs_cnt;
    push_exp(1);
    cfg_tready = 1'b1;
    rst_n = 1'b1;
    wait_hs(h + 1);
    repeat (3) tick();
    check("sb_empty", sb_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
